// File: rtl/param_memory.sv
// Byte-enabled single-port word memory that zero-fills itself after reset.
// Requests are accepted only once the clear sweep has finished.
module param_memory #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] datain,
  input  logic [DATA_W/8-1:0] be,
  input  logic              w,
  input  logic              r,
  output logic              ready,
  output logic [DATA_W-1:0] dataout,
  output logic              rvalid,
  output logic              err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ready_q;
  logic                rvalid_q;
  logic                err_q;
  logic [DATA_W-1:0]   dataout_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic in_rng;
  logic clr_en;
  logic wr_en;

  // Widen by one bit so DEPTH == 2**ADDR_W compares correctly.
  assign in_rng = {1'b0, adr} < DEPTH_W;
  assign clr_en = !rst && (state_q == INIT);
  assign wr_en  = !rst && (state_q == RUN) && w && in_rng;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      dataout_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (cnt_q == LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (w || r) err_q <= !in_rng;
          if (r) begin
            rvalid_q  <= 1'b1;
            dataout_q <= in_rng ? mem_q[adr] : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Clear sweep and byte-masked writes share the single write port.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[adr][8*i +: 8] <= datain[8*i +: 8];
      end
    end
  end

  assign ready   = ready_q;
  assign dataout = dataout_q;
  assign rvalid  = rvalid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory (DEPTH=200 so out-of-range
// addresses exist inside the 8-bit address space).
module tb_param_memory;

  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int DEPTH = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] adr;
  logic [DW-1:0] datain;
  logic [DW/8-1:0] be;
  logic          w;
  logic          r;
  logic          ready;
  logic [DW-1:0] dataout;
  logic          rvalid;
  logic          err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          w;
    logic          r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [7:0]    b;
    logic          ev;
    logic          ee;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  param_memory #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .adr    (adr),
    .datain (datain),
    .be     (be),
    .w      (w),
    .r      (r),
    .ready  (ready),
    .dataout(dataout),
    .rvalid (rvalid),
    .err    (err)
  );

  function automatic vec_t mk(
    input logic ww, input logic rr,
    input logic [AW-1:0] a, input logic [DW-1:0] d,
    input logic [7:0] b, input logic ev,
    input logic ee, input logic [DW-1:0] ed);
    vec_t v;
    v.w = ww; v.r = rr; v.a = a; v.d = d;
    v.b = b; v.ev = ev; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input logic ww, input logic rr,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input logic [7:0] b);
    w = ww; r = rr; adr = a; datain = d; be = b;
    @(posedge clk);
    @(negedge clk);
    w = 1'b0; r = 1'b0;
  endtask

  // Enter at a negedge; rst is seen on two edges, then released.
  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w = 1'b0; r = 1'b0;
    chk("rst_state", {ready, rvalid, err, dataout}, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input bit busy);
    int n = 0;
    bit bad = 1'b0;
    if (busy) begin
      w = 1'b1; r = 1'b1; adr = '0;
      datain = '1; be = '1;
    end
    while (ready !== 1'b1 && n < 4 * DEPTH) begin
      if (rvalid !== 1'b0 || err !== 1'b0) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    w = 1'b0; r = 1'b0; be = '0;
    chk("ready_latency", 72'(n), 72'(DEPTH));
    chk("busy_quiet", 72'(bad), 72'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; w = 1'b0; r = 1'b0;
    adr = '0; datain = '0; be = '0;

    tbl.push_back(mk(1, 0, 5, 64'h1122334455667788, 8'hFF, 0, 0, 64'h0));
    tbl.push_back(mk(1, 0, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0, 64'h0));
    tbl.push_back(mk(0, 1, 5, 64'h0, 8'h00, 1, 0, 64'h11223344AAAAAAAA));
    tbl.push_back(mk(0, 0, 5, 64'h0, 8'h00, 0, 0, 64'h11223344AAAAAAAA));
    tbl.push_back(mk(1, 0, 7, 64'h1, 8'hFF, 0, 0, 64'h11223344AAAAAAAA));
    tbl.push_back(mk(1, 1, 7, 64'h2, 8'hFF, 1, 0, 64'h1));
    tbl.push_back(mk(0, 1, 7, 64'h0, 8'h00, 1, 0, 64'h2));
    tbl.push_back(mk(1, 0, 9, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 0, 64'h2));
    tbl.push_back(mk(0, 1, 9, 64'h0, 8'h00, 1, 0, 64'h0));
    tbl.push_back(mk(1, 0, 199, 64'h55, 8'hFF, 0, 0, 64'h0));
    tbl.push_back(mk(0, 1, 199, 64'h0, 8'h00, 1, 0, 64'h55));
    tbl.push_back(mk(1, 0, 210, 64'h77, 8'hFF, 0, 1, 64'h55));
    tbl.push_back(mk(0, 1, 210, 64'h0, 8'h00, 1, 1, 64'h0));
    tbl.push_back(mk(0, 1, 199, 64'h0, 8'h00, 1, 0, 64'h55));
    tbl.push_back(mk(0, 1, 10, 64'h0, 8'h00, 1, 0, 64'h0));
    tbl.push_back(mk(1, 0, 200, 64'h99, 8'hFF, 0, 1, 64'h0));
    tbl.push_back(mk(0, 1, 255, 64'h0, 8'h00, 1, 1, 64'h0));
    tbl.push_back(mk(1, 0, 5, 64'h00CC000000000000, 8'h40, 0, 0, 64'h0));
    tbl.push_back(mk(0, 1, 5, 64'h0, 8'h00, 1, 0, 64'h11CC3344AAAAAAAA));
    tbl.push_back(mk(0, 0, 0, 64'h0, 8'h00, 0, 0, 64'h11CC3344AAAAAAAA));
    tbl.push_back(mk(1, 1, 200, 64'h0, 8'hFF, 1, 1, 64'h0));
    tbl.push_back(mk(0, 1, 7, 64'h0, 8'h00, 1, 0, 64'h2));

    @(negedge clk);
    pulse_rst();
    wait_ready(1'b1);

    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 1'b1, a[AW-1:0], '0, '0);
      chk($sformatf("clr_rd%0d", a), {rvalid, err, dataout},
          {1'b1, 1'b0, 64'h0});
    end

    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].b);
      chk($sformatf("vec%0d", i), {rvalid, err, dataout},
          {tbl[i].ev, tbl[i].ee, tbl[i].ed});
    end

    step(1'b1, 1'b0, 3, 64'hDEAD, 8'hFF);
    step(1'b0, 1'b1, 3, '0, '0);
    chk("dead_rd", {rvalid, err, dataout}, {1'b1, 1'b0, 64'hDEAD});

    r = 1'b1; adr = 3;
    pulse_rst();
    repeat (100) @(negedge clk);
    chk("mid_init_ready", 72'(ready), 72'(0));
    pulse_rst();
    wait_ready(1'b0);

    step(1'b0, 1'b1, 3, '0, '0);
    chk("rd3_after_rst", {rvalid, err, dataout}, {1'b1, 1'b0, 64'h0});
    step(1'b0, 1'b1, 5, '0, '0);
    chk("rd5_after_rst", {rvalid, err, dataout}, {1'b1, 1'b0, 64'h0});
    step(1'b0, 1'b0, 0, '0, '0);
    chk("idle_after_rst", {rvalid, err}, 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
